keypad_code_sender: RTL and testbench

Transmit side of the keypad digit interface: takes a 32-bit binary code and replays it as a sequence of keypad digit presses (8-bit `key` plus `button_pressed` strobe), most-significant decimal digit first. It drives the same signals the keypad accumulator consumes, so a stored or generated code can be re-entered into the lock path for self-test and auto-unlock. The code is converted to BCD internally, checked for digits the accumulator accepts (1..6), then emitted with programmable press and gap lengths.

---
 rtl/keypad_code_sender.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_code_sender.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_sender.sv
// Replays a 32-bit binary code as keypad digit presses, most-significant decimal digit first.
// Binary is converted to BCD by double-dabble, validated (digits 1..6 only), then strobed out.
module keypad_code_sender #(
   parameter int PRESS_CYCLES = 4,
   parameter int GAP_CYCLES   = 4
) (
   input  logic        hwclk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] value,
   output logic [7:0]  key,
   output logic        button_pressed,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int MAX_CYC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_SCAN    = 3'd2,
      S_PRESS   = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
      logic [39:0] r;
      r = b;
      for (int i = 0; i < 10; i++) begin
         if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
         else                     r[i*4 +: 4] = b[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [3:0] digit_count(input logic [39:0] b);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (b[i*4 +: 4] != 4'd0) n = 4'(i + 1);
         else                     n = n;
      end
      return n;
   endfunction

   // Any digit at or below the most-significant nonzero one must be 1..6.
   function automatic logic digits_illegal(input logic [39:0] b, input logic [3:0] n);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if ((4'(i) < n) && ((b[i*4 +: 4] == 4'd0) || (b[i*4 +: 4] > 4'd6))) bad = 1'b1;
         else                                                                 bad = bad;
      end
      return bad;
   endfunction

   state_t         state_q, state_d;
   logic [31:0]    bin_q, bin_d;
   logic [39:0]    bcd_q, bcd_d;
   logic [4:0]     iter_q, iter_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     idx_q, idx_d;
   logic [7:0]     key_q, key_d;
   logic           bp_q, bp_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [3:0]     scan_n_s;
   logic           scan_bad_s;

   assign scan_n_s   = digit_count(bcd_q);
   assign scan_bad_s = digits_illegal(bcd_q, scan_n_s);

   // State and datapath registers.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         bin_q   <= 32'd0;
         bcd_q   <= 40'd0;
         iter_q  <= 5'd0;
         cnt_q   <= '0;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d   = value;
               bcd_d   = 40'd0;
               iter_d  = 5'd0;
               state_d = S_CONVERT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CONVERT: begin
            bcd_d  = {dabble_adjust(bcd_q)[38:0], bin_q[31]};
            bin_d  = {bin_q[30:0], 1'b0};
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd31) state_d = S_SCAN;
            else                 state_d = S_CONVERT;
         end
         S_SCAN: begin
            cnt_d = '0;
            if (scan_bad_s || (scan_n_s == 4'd0)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = scan_n_s - 4'd1;
               state_d = S_PRESS;
            end
         end
         S_PRESS: begin
            if (cnt_q == PRESS_LAST) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q != GAP_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (idx_q == 4'd0) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d   = '0;
               idx_d   = idx_q - 4'd1;
               state_d = S_PRESS;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are derived from the next state so they change on the same edge as the state.
   always_comb begin
      key_d  = 8'd0;
      bp_d   = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      err_d  = err_q;
      case (state_d)
         S_CONVERT, S_SCAN, S_GAP: busy_d = 1'b1;
         S_PRESS: begin
            busy_d = 1'b1;
            bp_d   = 1'b1;
            key_d  = {4'd0, bcd_q[{idx_d, 2'b00} +: 4]};
         end
         S_DONE:  done_d = 1'b1;
         default: busy_d = 1'b0;
      endcase
      if ((state_q == S_IDLE) && start)        err_d = 1'b0;
      else if ((state_q == S_SCAN) && scan_bad_s) err_d = 1'b1;
      else                                     err_d = err_q;
   end

   // Registered outputs.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         key_q  <= 8'd0;
         bp_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         key_q  <= key_d;
         bp_q   <= bp_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign key            = key_q;
   assign button_pressed = bp_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = err_q;

endmodule

// File: tb/tb_keypad_code_sender.sv
// Scoreboard bench: expected presses are queued when a code is sent and popped as strobes appear.
module tb_keypad_code_sender;

   logic        hwclk = 1'b0;
   logic        reset;
   logic        start0, start1;
   logic [31:0] value0, value1;
   logic [7:0]  key0, key1;
   logic        bp0, bp1, busy0, busy1, done0, done1, err0, err1;

   keypad_code_sender dut0 (
      .hwclk(hwclk), .reset(reset), .start(start0), .value(value0),
      .key(key0), .button_pressed(bp0), .busy(busy0), .done(done0), .error(err0)
   );

   keypad_code_sender #(.PRESS_CYCLES(1), .GAP_CYCLES(2)) dut1 (
      .hwclk(hwclk), .reset(reset), .start(start1), .value(value1),
      .key(key1), .button_pressed(bp1), .busy(busy1), .done(done1), .error(err1)
   );

   always #5 hwclk = ~hwclk;

   typedef struct {
      int digit;
      int cyc;
   } exp_t;

   exp_t   exp_q[$];
   int     cyc = 0;
   int     n_checks = 0;
   int     n_errors = 0;
   longint acc0 = 0;
   int     got1_key[$];
   int     got1_cyc[$];

   task automatic check_eq(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge hwclk);
      cyc++;
   end

   // dut0 monitor: pops the scoreboard on every strobe rise, checks width and key stability.
   initial begin : mon0
      int   width0;
      logic prev0;
      int   last_key;
      exp_t e;
      width0 = 0; prev0 = 1'b0; last_key = 0;
      forever begin
         @(negedge hwclk);
         if (reset) begin
            width0 = 0;
            prev0  = 1'b0;
         end else begin
            if (bp0 && !prev0) begin
               acc0     = acc0 * 10 + longint'(key0);
               last_key = int'(key0);
               if (exp_q.size() == 0) check_eq("unexpected_press", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check_eq("press_key", key0, e.digit);
                  check_eq("press_cycle", cyc, e.cyc);
               end
            end else if (bp0) begin
               check_eq("key_stable", key0, last_key);
            end
            if (bp0) width0++;
            else if (prev0) begin
               check_eq("press_width", width0, 4);
               width0 = 0;
            end
            if (!bp0) check_eq("key_zero_idle", key0, 0);
            prev0 = bp0;
         end
      end
   end

   // dut1 monitor: records keys and rise cycles, checks single-cycle strobes.
   initial begin : mon1
      int   width1;
      logic prev1;
      width1 = 0; prev1 = 1'b0;
      forever begin
         @(negedge hwclk);
         if (reset) begin
            width1 = 0;
            prev1  = 1'b0;
         end else begin
            if (bp1 && !prev1) begin
               got1_key.push_back(int'(key1));
               got1_cyc.push_back(cyc);
            end
            if (bp1) width1++;
            else if (prev1) begin
               check_eq("press_width_p1", width1, 1);
               width1 = 0;
            end
            prev1 = bp1;
         end
      end
   end

   task automatic model_digits(input logic [31:0] v, output int d[$], output bit bad);
      longint x;
      d = {};
      x = longint'(v);
      while (x != 0) begin
         d.push_front(int'(x % 10));
         x = x / 10;
      end
      bad = 1'b0;
      foreach (d[k]) if (d[k] == 0 || d[k] > 6) bad = 1'b1;
   endtask

   task automatic send0(input logic [31:0] v, input bit noisy);
      int d[$];
      bit bad;
      int e0, exp_done;
      bit seen;
      model_digits(v, d, bad);
      @(negedge hwclk);
      start0 = 1'b1;
      value0 = v;
      acc0   = 0;
      @(negedge hwclk);
      start0 = 1'b0;
      e0     = cyc;
      check_eq("busy_accept", busy0, 1);
      check_eq("error_cleared", err0, 0);
      if (!bad) foreach (d[k]) exp_q.push_back(exp_t'{d[k], e0 + 33 + 8 * k});
      exp_done = bad ? e0 + 33 : e0 + 33 + 8 * d.size();
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge hwclk);
         if (noisy) begin
            start0 = (i == 10 || i == 30);
            value0 = 32'd66;
         end
         if (done0) seen = 1'b1;
         else       check_eq("busy_held", busy0, 1);
      end
      start0 = 1'b0;
      check_eq("done_seen", seen, 1);
      if (seen) begin
         check_eq("done_cycle", cyc, exp_done);
         check_eq("busy_at_done", busy0, 0);
         check_eq("error_flag", err0, bad);
         check_eq("presses_left", exp_q.size(), 0);
         if (!bad) check_eq("loopback", acc0, longint'(v));
      end
      exp_q.delete();
      @(negedge hwclk);
      check_eq("idle_after_done", busy0, 0);
      check_eq("done_one_cycle", done0, 0);
      check_eq("error_hold", err0, bad);
   endtask

   initial begin : main
      int d[$];
      bit bad;
      int e0;
      bit seen;
      reset  = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      value0 = 32'd0; value1 = 32'd0;
      repeat (3) @(negedge hwclk);
      check_eq("rst_key", key0, 0);
      check_eq("rst_bp", bp0, 0);
      check_eq("rst_busy", busy0, 0);
      check_eq("rst_done", done0, 0);
      check_eq("rst_error", err0, 0);
      reset = 1'b0;
      @(negedge hwclk);

      send0(32'd123, 1'b0);
      send0(32'd0, 1'b0);
      send0(32'd105, 1'b0);
      repeat (3) @(negedge hwclk);
      check_eq("error_hold_long", err0, 1);
      send0(32'd7, 1'b0);

      // Ten-digit code on the short-timing instance.
      model_digits(32'd4166666666, d, bad);
      @(negedge hwclk);
      start1 = 1'b1;
      value1 = 32'd4166666666;
      @(negedge hwclk);
      start1 = 1'b0;
      e0     = cyc;
      seen   = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge hwclk);
         if (done1) seen = 1'b1;
      end
      check_eq("p1_done_seen", seen, 1);
      if (seen) check_eq("p1_done_cycle", cyc, e0 + 63);
      check_eq("p1_error", err1, 0);
      check_eq("p1_press_count", got1_key.size(), 10);
      for (int k = 0; k < 10 && k < got1_key.size(); k++) begin
         check_eq("p1_key", got1_key[k], d[k]);
         check_eq("p1_press_cycle", got1_cyc[k], e0 + 33 + 3 * k);
      end

      // Reset in the middle of the second press of 123.
      @(negedge hwclk);
      start0 = 1'b1;
      value0 = 32'd123;
      acc0   = 0;
      @(negedge hwclk);
      start0 = 1'b0;
      e0     = cyc;
      exp_q.push_back(exp_t'{1, e0 + 33});
      exp_q.push_back(exp_t'{2, e0 + 41});
      repeat (42) @(negedge hwclk);
      check_eq("mid_press", bp0, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("arst_key", key0, 0);
      check_eq("arst_bp", bp0, 0);
      check_eq("arst_busy", busy0, 0);
      check_eq("arst_done", done0, 0);
      check_eq("arst_error", err0, 0);
      check_eq("arst_presses_seen", exp_q.size(), 0);
      exp_q.delete();
      @(negedge hwclk);
      reset = 1'b0;
      @(negedge hwclk);

      send0(32'd45, 1'b1);
      send0(32'd3521, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
